dmem_lsu_bridge: RTL and testbench
==================================

// Module: dmem_lsu_bridge
// PURPOSE
//  Core-side front end of the single-port data RAM. It takes load/store requests on a req/gnt/rvalid bus.
//  Outputs: RAM enable, word address, byte enables and lane-shifted write data. Loads are returned aligned
//  and zero/sign-extended. Misaligned halfword/word accesses that cross a word are split into two RAM accesses.
// PARAMETERS
//  ADDR_WIDTH  8    RAM byte-address width (RAM ignores addr[1:0])
//  DATA_WIDTH  32   data width; only 32 supported (elaboration error otherwise)
//  NUM_WORDS   256  RAM capacity in bytes; legal byte addresses 0..NUM_WORDS-1
// PORTS
//  clk             in   1           clock, all state on rising edge
//  rstn_i          in   1           asynchronous active-low reset
//  data_req_i      in   1           core request valid
//  data_gnt_o      out  1           request accepted this cycle (combinational)
//  data_addr_i     in   32          byte address
//  data_we_i       in   1           1=store 0=load
//  data_size_i     in   2           00 byte, 01 half, 10 word, 11 illegal (->error)
//  data_sign_ext_i in   1           sign-extend load result
//  data_wdata_i    in   32          store data, LSB-justified
//  data_rvalid_o   out  1           response valid (loads and stores), registered
//  data_rdata_o    out  32          load result; 0 for stores/errors
//  data_err_o      out  1           qualifies rvalid: out-of-range or illegal size
//  ram_en_o        out  1           RAM access strobe
//  ram_we_o        out  1           RAM write
//  ram_addr_o      out  ADDR_WIDTH  word-aligned byte address (bits[1:0]=00)
//  ram_be_o        out  4           byte enables
//  ram_wdata_o     out  32          lane-aligned write data
//  ram_rdata_i     in   32          RAM read data, valid 1 cycle after en
// BEHAVIOUR
//  Reset: state=IDLE, rvalid/err/rdata=0, hold regs=0. RAM-side outputs are combinational and 0 in IDLE with no req.
//  Reset mid-operation: pending split access dropped, no rvalid issued, second RAM access suppressed.
//  off=addr[1:0]; misaligned-split = (half & off==3) | (word & off!=0).
//  Error = size==11 | addr+bytes-1 >= NUM_WORDS (32-bit compare, no wrap).
//  On error: gnt=1, no ram_en, next cycle rvalid=1 err=1 rdata=0.
//  FSM states: IDLE, SPLIT2, RESP2.
//   IDLE: gnt=req. Aligned: RAM access issued in the gnt cycle; rvalid exactly 1 cycle later. Back-to-back
//         aligned requests: gnt every cycle, one rvalid per cycle, in order.
//   IDLE->SPLIT2 on granted split: first access word addr[..:2], be=lanes off..3.
//   SPLIT2: gnt=0. Second access to word+1, be=remaining low lanes. Latch first rdata (loads) into hold reg.
//           ->RESP2.
//   RESP2: rvalid=1, rdata={ram_rdata_i low lanes, hold high lanes} shifted right by off*8, then extended.
//          gnt=req (new request may be accepted same cycle) -> IDLE or SPLIT2.
//  Split latency: rvalid 2 cycles after gnt. Split stores: the first access carries the low data bytes.
//  be: byte 0001<<off; half 0011<<off; word 1111; split portions masked to lanes.
//  wdata: ram_wdata_o = wdata_i << off*8 (first access), wdata_i >> (4-off)*8 (second).
//  Load extension: byte/half sign- or zero-extended per data_sign_ext_i latched at gnt; word unchanged.
//  Request fields are latched at gnt; the core may change them after gnt.
// STRUCTURE
//  dmem_pkg: size_e {SZ_B,SZ_H,SZ_W,SZ_X}, state_e {IDLE,SPLIT2,RESP2}, function be_gen(size,off).
//  Sub-module dmem_align (combinational): lane shift + sign/zero extend for load data.
//  The top holds the FSM, request latch, hold register, error check and store lane shifting.
// TESTING (RAM model preloaded: [0x10]=0x88776655, [0x14]=0xCCBBAA99)
//  1 LB 0x13 sext=1 -> be 1000 at 0x10, rdata 0xFFFFFF88; LBU 0x13 -> 0x00000088, rvalid 1 cycle after gnt.
//  2 SH 0x1234 @0x12 -> ram_be 1100, ram_wdata 0x12340000; subsequent LHU 0x12 -> 0x00001234.
//  3 LW 0x13 -> accesses 0x10 then 0x14, gnt low in second cycle, rdata 0xBBAA9988 2 cycles after gnt.
//  4 SW 0x11223344 @0x17 -> (0x14,be 1000,wd 0x44000000) then (0x18,be 0111,wd 0x00112233), err=0.
//  5 LW 0xFE and LB 0x100 with NUM_WORDS=256 -> no ram_en, rvalid+err, rdata 0; size=11 -> err.
//  6 10 back-to-back aligned SW/LW, random data: one rvalid per cycle, in order, scoreboard match.
//    Assert rstn_i in SPLIT2: no second access, no rvalid, next request is served normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory load/store bridge.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_X = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SPLIT2 = 2'b01,
    RESP2  = 2'b10
  } state_e;

  // Byte-lane mask over two consecutive words: [3:0] first word, [7:4] second word.
  function automatic logic [7:0] be_gen(size_e size, logic [1:0] off);
    logic [7:0] mask;
    case (size)
      SZ_B:    mask = 8'h01;
      SZ_H:    mask = 8'h03;
      default: mask = 8'h0F;
    endcase
    return mask << off;
  endfunction

  function automatic logic [2:0] size_bytes(size_e size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Core-side req/gnt/rvalid load/store bus.
interface dmem_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr, we, size, sign_ext, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, size, sign_ext, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dmem_align.sv
// Load-data alignment: picks the addressed bytes out of up to two RAM words and extends them.
module dmem_align
  import dmem_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [31:0] lanes;

  always_comb begin
    lanes = 32'(data >> {off, 3'b000});
    case (size)
      SZ_B:    result = {{24{sign_ext & lanes[7]}}, lanes[7:0]};
      SZ_H:    result = {{16{sign_ext & lanes[15]}}, lanes[15:0]};
      default: result = lanes;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_bridge.sv
// Core-side front end of the single-port data RAM: range check, lane steering, and splitting of
// word-crossing accesses into two RAM cycles.
module dmem_lsu_bridge
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  dmem_if.slave                 bus,
  output logic                  ram_en_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  if (DATA_WIDTH != 32) begin : g_width_check
    $error("dmem_lsu_bridge supports DATA_WIDTH == 32 only");
  end

  state_e                state_q, state_d;
  size_e                 req_size, size_q;
  logic [1:0]            req_off;
  logic [3:0]            req_be, split_be;
  logic [32:0]           end_addr;
  logic                  req_err, req_split, accept;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-3:0] next_word;
  logic                  we_q, sext_q, err_q, rvalid_q;
  logic [31:0]           wdata_q, hold_q, align_out;
  logic [63:0]           align_in;

  assign req_size  = size_e'(bus.size);
  assign req_off   = bus.addr[1:0];
  assign req_be    = 4'(be_gen(req_size, req_off));
  assign split_be  = 4'(be_gen(size_q, addr_q[1:0]) >> 4);
  assign next_word = addr_q[ADDR_WIDTH-1:2] + (ADDR_WIDTH-2)'(1);

  // 33-bit end address so addresses near 2^32 cannot wrap into the legal range.
  assign end_addr  = {1'b0, bus.addr} + 33'(size_bytes(req_size)) - 33'd1;
  assign req_err   = (req_size == SZ_X) || (end_addr >= 33'(NUM_WORDS));
  assign req_split = ((req_size == SZ_H) && (req_off == 2'd3)) ||
                     ((req_size == SZ_W) && (req_off != 2'd0));

  always_comb begin
    state_d     = state_q;
    bus.gnt     = 1'b0;
    accept      = 1'b0;
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    case (state_q)
      SPLIT2: begin
        ram_en_o   = 1'b1;
        ram_we_o   = we_q;
        ram_addr_o = {next_word, 2'b00};
        ram_be_o   = split_be;
        // Second portion carries the upper data bytes; shift is (4-off)*8 modulo 32.
        if (we_q) ram_wdata_o = wdata_q >> (5'd0 - {addr_q[1:0], 3'b000});
        state_d    = RESP2;
      end
      default: begin
        bus.gnt = bus.req;
        accept  = bus.req;
        state_d = IDLE;
        if (bus.req && !req_err) begin
          ram_en_o   = 1'b1;
          ram_we_o   = bus.we;
          ram_addr_o = {bus.addr[ADDR_WIDTH-1:2], 2'b00};
          ram_be_o   = req_be;
          if (bus.we) ram_wdata_o = bus.wdata << {req_off, 3'b000};
          if (req_split) state_d = SPLIT2;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      size_q   <= SZ_B;
      sext_q   <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= (accept && (req_err || !req_split)) || (state_q == SPLIT2);
      if (accept) begin
        addr_q  <= bus.addr[ADDR_WIDTH-1:0];
        we_q    <= bus.we;
        size_q  <= req_size;
        sext_q  <= bus.sign_ext;
        wdata_q <= bus.wdata;
        err_q   <= req_err;
      end
      if (state_q == SPLIT2) hold_q <= ram_rdata_i;
    end
  end

  assign align_in = (state_q == RESP2) ? {ram_rdata_i, hold_q} : {32'h0, ram_rdata_i};

  dmem_align u_align (
    .data     (align_in),
    .off      (addr_q[1:0]),
    .size     (size_q),
    .sign_ext (sext_q),
    .result   (align_out)
  );

  assign bus.rvalid = rvalid_q;
  assign bus.err    = rvalid_q & err_q;
  assign bus.rdata  = (rvalid_q && !err_q && !we_q) ? align_out : 32'h0;

endmodule

// File: tb/tb_dmem_lsu_bridge.sv
// Bench for dmem_lsu_bridge: byte-level golden memory model plus directed literal checks.
module tb_dmem_lsu_bridge;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dmem_if bus ();

  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata, ram_rdata;

  dmem_lsu_bridge #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .NUM_WORDS  (256)
  ) dut (
    .clk         (clk),
    .rstn_i      (rstn),
    .bus         (bus.slave),
    .ram_en_o    (ram_en),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_be_o    (ram_be),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cnt = 0;

  logic [31:0] ram [0:63];
  logic [7:0]  gold [0:255];

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // RAM: one-cycle read latency, byte-lane writes.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_en) begin
      acc_cnt <= acc_cnt + 1;
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) ram[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= ram[ram_addr[7:2]];
      end
    end
  end

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Expected response straight from byte addresses in the golden memory.
  function automatic exp_t model(input logic [31:0] a, input logic we, input logic [1:0] sz,
                                 input logic sx, input int c);
    exp_t e;
    int   n;
    logic crosses;
    n = nbytes(sz);
    e.err = (sz == 2'b11) || (({32'h0, a} + 64'(n) - 64'd1) >= 64'd256);
    crosses = (int'(a[1:0]) + n) > 4;
    e.due = c + ((crosses && !e.err) ? 2 : 1);
    e.rdata = 32'h0;
    if (!e.err && !we) begin
      for (int j = 0; j < n; j++) e.rdata = e.rdata | (32'(gold[int'(a[7:0]) + j]) << (8 * j));
      if (sx && n == 1 && e.rdata[7])  e.rdata = e.rdata | 32'hFFFF_FF00;
      if (sx && n == 2 && e.rdata[15]) e.rdata = e.rdata | 32'hFFFF_0000;
    end
    return e;
  endfunction

  exp_t got_e, new_e;
  always @(negedge clk) begin
    if (!rstn) begin
      exp_q.delete();
    end else begin
      if (bus.rvalid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_rvalid: got rvalid=1 expected no response (cycle %0d)", cyc);
        end else begin
          got_e = exp_q.pop_front();
          check("resp_cycle", 32'(cyc), 32'(got_e.due));
          check("resp_rdata", bus.rdata, got_e.rdata);
          check("resp_err", 32'(bus.err), 32'(got_e.err));
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        total++;
        bad++;
        $display("FAIL missing_rvalid: got rvalid=0 expected response due cycle %0d", exp_q[0].due);
        void'(exp_q.pop_front());
      end
      if (bus.req && bus.gnt) begin
        new_e = model(bus.addr, bus.we, bus.size, bus.sign_ext, cyc);
        exp_q.push_back(new_e);
        if (bus.we && !new_e.err)
          for (int j = 0; j < nbytes(bus.size); j++)
            gold[int'(bus.addr[7:0]) + j] = bus.wdata[8*j +: 8];
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic we, input logic [1:0] sz,
                       input logic sx, input logic [31:0] wd);
    @(posedge clk);
    #1;
    bus.req = 1'b1;
    bus.addr = a;
    bus.we = we;
    bus.size = sz;
    bus.sign_ext = sx;
    bus.wdata = wd;
    @(negedge clk);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    bus.addr = 32'h0;
    bus.we = 1'b0;
    bus.size = 2'b00;
    bus.sign_ext = 1'b0;
    bus.wdata = 32'h0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int start_cnt;
    logic [31:0] a, wd;
    logic we;

    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    ram[4] = 32'h8877_6655;
    ram[5] = 32'hCCBB_AA99;
    ram_rdata = 32'h0;
    for (int i = 0; i < 256; i++) gold[i] = ram[i / 4][8*(i % 4) +: 8];
    bus.req = 1'b0;
    bus.addr = 32'h0;
    bus.we = 1'b0;
    bus.size = 2'b00;
    bus.sign_ext = 1'b0;
    bus.wdata = 32'h0;

    @(negedge clk);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1;

    // LB / LBU at the top byte of a word.
    drive(32'h13, 1'b0, 2'b00, 1'b1, 32'h0);
    check("lb_gnt", 32'(bus.gnt), 32'd1);
    check("lb_en", 32'(ram_en), 32'd1);
    check("lb_addr", 32'(ram_addr), 32'h10);
    check("lb_be", 32'(ram_be), 32'b1000);
    idle();
    check("lb_rvalid", 32'(bus.rvalid), 32'd1);
    check("lb_rdata", bus.rdata, 32'hFFFF_FF88);
    drive(32'h13, 1'b0, 2'b00, 1'b0, 32'h0);
    idle();
    check("lbu_rvalid", 32'(bus.rvalid), 32'd1);
    check("lbu_rdata", bus.rdata, 32'h0000_0088);

    // Split LW, with a second request waiting through SPLIT2.
    drive(32'h13, 1'b0, 2'b10, 1'b0, 32'h0);
    check("lw13_gnt", 32'(bus.gnt), 32'd1);
    check("lw13_addr1", 32'(ram_addr), 32'h10);
    check("lw13_be1", 32'(ram_be), 32'b1000);
    drive(32'h14, 1'b0, 2'b10, 1'b0, 32'h0);
    check("lw13_gnt2", 32'(bus.gnt), 32'd0);
    check("lw13_en2", 32'(ram_en), 32'd1);
    check("lw13_addr2", 32'(ram_addr), 32'h14);
    check("lw13_be2", 32'(ram_be), 32'b0111);
    check("lw13_novalid", 32'(bus.rvalid), 32'd0);
    drive(32'h14, 1'b0, 2'b10, 1'b0, 32'h0);
    check("resp2_gnt", 32'(bus.gnt), 32'd1);
    check("lw13_rvalid", 32'(bus.rvalid), 32'd1);
    check("lw13_rdata", bus.rdata, 32'hBBAA_9988);
    check("lw14_addr", 32'(ram_addr), 32'h14);
    check("lw14_be", 32'(ram_be), 32'b1111);
    idle();
    check("lw14_rdata", bus.rdata, 32'hCCBB_AA99);

    // SH then LHU.
    drive(32'h12, 1'b1, 2'b01, 1'b0, 32'h1234);
    check("sh_we", 32'(ram_we), 32'd1);
    check("sh_addr", 32'(ram_addr), 32'h10);
    check("sh_be", 32'(ram_be), 32'b1100);
    check("sh_wdata", ram_wdata, 32'h1234_0000);
    idle();
    check("sh_rvalid", 32'(bus.rvalid), 32'd1);
    check("sh_rdata", bus.rdata, 32'h0);
    drive(32'h12, 1'b0, 2'b01, 1'b0, 32'h0);
    idle();
    check("lhu_rdata", bus.rdata, 32'h0000_1234);

    // Split SW.
    drive(32'h17, 1'b1, 2'b10, 1'b0, 32'h1122_3344);
    check("sw17_addr1", 32'(ram_addr), 32'h14);
    check("sw17_be1", 32'(ram_be), 32'b1000);
    check("sw17_wd1", ram_wdata, 32'h4400_0000);
    idle();
    check("sw17_en2", 32'(ram_en), 32'd1);
    check("sw17_addr2", 32'(ram_addr), 32'h18);
    check("sw17_be2", 32'(ram_be), 32'b0111);
    check("sw17_wd2", ram_wdata, 32'h0011_2233);
    check("sw17_novalid", 32'(bus.rvalid), 32'd0);
    idle();
    check("sw17_rvalid", 32'(bus.rvalid), 32'd1);
    check("sw17_err", 32'(bus.err), 32'd0);

    // Range and size errors, plus the legal top byte.
    drive(32'hFE, 1'b0, 2'b10, 1'b0, 32'h0);
    check("lwfe_gnt", 32'(bus.gnt), 32'd1);
    check("lwfe_en", 32'(ram_en), 32'd0);
    idle();
    check("lwfe_err", 32'(bus.err), 32'd1);
    check("lwfe_rdata", bus.rdata, 32'h0);
    drive(32'h100, 1'b0, 2'b00, 1'b0, 32'h0);
    check("lb100_en", 32'(ram_en), 32'd0);
    idle();
    check("lb100_err", 32'(bus.err), 32'd1);
    drive(32'h20, 1'b0, 2'b11, 1'b0, 32'h0);
    check("sz11_en", 32'(ram_en), 32'd0);
    idle();
    check("sz11_err", 32'(bus.err), 32'd1);
    drive(32'hFFFF_FFFE, 1'b0, 2'b10, 1'b0, 32'h0);
    check("wrap_en", 32'(ram_en), 32'd0);
    idle();
    check("wrap_err", 32'(bus.err), 32'd1);
    drive(32'hFF, 1'b0, 2'b00, 1'b0, 32'h0);
    check("lbff_en", 32'(ram_en), 32'd1);
    idle();
    check("lbff_err", 32'(bus.err), 32'd0);

    // Back-to-back aligned traffic.
    for (int i = 0; i < 10; i++) begin
      a  = 32'h40 + 32'(4 * $urandom_range(0, 3));
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      drive(a, we, 2'b10, 1'b0, wd);
      check("b2b_gnt", 32'(bus.gnt), 32'd1);
      check("b2b_rvalid", 32'(bus.rvalid), (i > 0) ? 32'd1 : 32'd0);
    end
    idle();
    check("b2b_last", 32'(bus.rvalid), 32'd1);

    // Reset while in SPLIT2.
    drive(32'h31, 1'b0, 2'b10, 1'b0, 32'h0);
    check("rstsp_addr1", 32'(ram_addr), 32'h30);
    idle();
    start_cnt = acc_cnt;
    rstn = 1'b0;
    #1;
    check("rstsp_en", 32'(ram_en), 32'd0);
    check("rstsp_rvalid", 32'(bus.rvalid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rstsp_rvalid2", 32'(bus.rvalid), 32'd0);
    check("rstsp_acc", 32'(acc_cnt), 32'(start_cnt));
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("rstsp_rvalid3", 32'(bus.rvalid), 32'd0);
    drive(32'h14, 1'b0, 2'b10, 1'b0, 32'h0);
    check("post_rst_gnt", 32'(bus.gnt), 32'd1);
    idle();
    check("post_rst_rdata", bus.rdata, 32'h44BB_AA99);

    idle();
    idle();
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
